// File: rtl/alu_mul_seq.sv
//============================================================================
// Module   : alu_mul_seq (with pkg_reg and pkg_alu)
// Purpose  : Multi-cycle unsigned shift-and-add multiplier sequencer. Builds
//            a 2*WIDTH-bit product by reusing the shared ALU's ALU_ADD path
//            and carry-out for every partial-sum step. Sits between the
//            control unit (start/busy/done handshake) and the ALU (op/a/b).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports:
//   clk      in   1      system clock, posedge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      multiply request, sampled in IDLE or DONE only
//   mcand    in   WIDTH  multiplicand, captured on accepted start
//   mplier   in   WIDTH  multiplier, captured on accepted start
//   busy     out  1      high while in RUN
//   done     out  1      one-cycle pulse in DONE
//   prod_hi  out  WIDTH  upper product half
//   prod_lo  out  WIDTH  lower product half
//   alu_op   out  op     ALU operation (ALU_NOP outside RUN)
//   alu_a    out  WIDTH  ALU operand a
//   alu_b    out  WIDTH  ALU operand b
//   alu_s    in   WIDTH  ALU result (combinational)
//   alu_cf   in   1      ALU carry-out (combinational)
//----------------------------------------------------------------------------
// Optional build macro: MUL_SEQ_EARLY_EXIT_EN
//   When defined, RUN ends early once the remaining multiplier bits are all
//   zero; the remaining shifts are applied in one cycle with alu_op=ALU_NOP.
//============================================================================
`default_nettype none

package pkg_reg;
  localparam int REG_WIDTH = 16;
endpackage

package pkg_alu;
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5
  } alu_op_t;
endpackage

module alu_mul_seq
  import pkg_alu::*;
#(
  parameter int WIDTH = pkg_reg::REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output alu_op_t          alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_hi,    w_hi_nxt;
  logic [WIDTH-1:0] r_lo,    w_lo_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // After k steps the low (WIDTH-k) = cnt bits of lo still hold unconsumed
  // multiplier bits; shifting lo left by k discards the product bits above
  // them, so the result is zero exactly when nothing is left to add.
  logic [CNT_W-1:0] w_consumed;
  logic [WIDTH-1:0] w_unconsumed;
  logic             w_rem_zero;

  assign w_consumed   = c_CNT_LOAD - r_cnt;
  assign w_unconsumed = r_lo << w_consumed;
  assign w_rem_zero   = (w_unconsumed == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mcand <= w_mcand_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mcand_nxt = r_mcand;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_cnt_nxt   = r_cnt;
    alu_op      = ALU_NOP;
    alu_a       = '0;
    alu_b       = '0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_mcand_nxt = mcand;
          w_hi_nxt    = '0;
          w_lo_nxt    = mplier;
          w_cnt_nxt   = c_CNT_LOAD;
          w_state_nxt = S_RUN;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_RUN: begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
        if (w_rem_zero) begin
          // Remaining steps would only add zero: apply all pending shifts now.
          {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} >> r_cnt;
          w_cnt_nxt            = '0;
          w_state_nxt          = S_DONE;
        end else
`endif
        begin
          alu_op = ALU_ADD;
          alu_a  = r_lo[0] ? r_mcand : '0;
          alu_b  = r_hi;
          // Carry becomes the new top bit; the sum's LSB drops into lo as a
          // finished product bit while the consumed multiplier bit shifts out.
          {w_hi_nxt, w_lo_nxt} = {alu_cf, alu_s, r_lo[WIDTH-1:1]};
          w_cnt_nxt            = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign prod_hi = r_hi;
  assign prod_lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
//============================================================================
// Module   : tb_alu_mul_seq
// Purpose  : Directed self-checking bench for alu_mul_seq at WIDTH=8, with a
//            behavioural ALU adder closing the op/a/b -> s/cf loop.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_alu_mul_seq;
  import pkg_alu::*;

  localparam int W = 8;
`ifdef MUL_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;
  logic         busy, done;
  logic [W-1:0] prod_hi, prod_lo;
  alu_op_t      alu_op;
  logic [W-1:0] alu_a, alu_b, alu_s;
  logic         alu_cf;

  int errors = 0;
  int checks = 0;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_s   (alu_s),
    .alu_cf  (alu_cf)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: only the add path matters here.
  always_comb begin
    alu_s  = '0;
    alu_cf = 1'b0;
    if (alu_op == ALU_ADD) {alu_cf, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected RUN length from the multiplier value.
  function automatic int exp_runs(input logic [W-1:0] m);
    int msb;
    if (!EARLY) return W;
    if (m == '0) return 1;
    msb = 0;
    for (int i = 0; i < W; i++) if (m[i]) msb = i;
    return (msb + 2 > W) ? W : msb + 2;
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int runs, output bit cf_seen, output bit op_bad, output bit got);
    runs = 0; cf_seen = 1'b0; op_bad = 1'b0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) begin
        runs++;
        if (alu_cf) cf_seen = 1'b1;
        if (alu_op !== ALU_ADD && !(EARLY && alu_op === ALU_NOP)) op_bad = 1'b1;
      end else if (alu_op !== ALU_NOP) begin
        op_bad = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    int  runs;
    bit  cf_seen, op_bad, got, saw_done;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", {prod_hi, prod_lo}, 16'h0000);
    check("rst_op", alu_op, ALU_NOP);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 13 x 11 = 143
    start_op(8'd13, 8'd11, 1'b0);
    check("t1_busy", busy, 1);
    check("t1_a0", alu_a, 13);
    check("t1_b0", alu_b, 0);
    wait_done(runs, cf_seen, op_bad, got);
    check("t1_got_done", got, 1);
    check("t1_runs", runs, exp_runs(8'd11));
    check("t1_prod", {prod_hi, prod_lo}, 16'h008F);
    check("t1_op", op_bad, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_hold", {prod_hi, prod_lo}, 16'h008F);

    // 0xFF x 0xFF = 0xFE01, carry must appear
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done(runs, cf_seen, op_bad, got);
    check("t2_got_done", got, 1);
    check("t2_runs", runs, 8);
    check("t2_prod", {prod_hi, prod_lo}, 16'hFE01);
    check("t2_cf_seen", cf_seen, 1);
    tick();

    // 0x5A x 0 with start held through RUN
    start_op(8'h5A, 8'h00, 1'b1);
    wait_done(runs, cf_seen, op_bad, got);
    start = 1'b0;
    check("t3_got_done", got, 1);
    check("t3_runs", runs, exp_runs(8'h00));
    check("t3_prod", {prod_hi, prod_lo}, 16'h0000);
    tick();
    check("t3_no_rerun", busy, 0);

    // 0 x 0xB5
    start_op(8'h00, 8'hB5, 1'b0);
    wait_done(runs, cf_seen, op_bad, got);
    check("t4_prod", {prod_hi, prod_lo}, 16'h0000);
    check("t4_runs", runs, exp_runs(8'hB5));
    tick();

    // Back-to-back: 2x2 then start in DONE with 3x4
    start_op(8'd2, 8'd2, 1'b0);
    wait_done(runs, cf_seen, op_bad, got);
    check("t5_got_done", got, 1);
    check("t5_prod1", {prod_hi, prod_lo}, 16'h0004);
    mcand  = 8'd3;
    mplier = 8'd4;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("t5_rebusy", busy, 1);
    check("t5_done_clr", done, 0);
    wait_done(runs, cf_seen, op_bad, got);
    check("t5_got_done2", got, 1);
    check("t5_runs2", runs, exp_runs(8'd4));
    check("t5_prod2", {prod_hi, prod_lo}, 16'h000C);
    tick();

    // Reset in RUN cycle 4
    start_op(8'hFF, 8'hFF, 1'b0);
    tick(); tick(); tick();
    check("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_prod", {prod_hi, prod_lo}, 16'h0000);
    check("t6_op", alu_op, ALU_NOP);
    check("t6_ab", {alu_a, alu_b}, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    check("t6_no_done", saw_done, 0);
    start_op(8'd6, 8'd7, 1'b0);
    wait_done(runs, cf_seen, op_bad, got);
    check("t6_got_done", got, 1);
    check("t6_prod2", {prod_hi, prod_lo}, 16'h002A);
    tick();

    // 7 x 2: latency depends on the early-exit build
    start_op(8'd7, 8'd2, 1'b0);
    wait_done(runs, cf_seen, op_bad, got);
    check("t7_got_done", got, 1);
    check("t7_runs", runs, EARLY ? 3 : 8);
    check("t7_prod", {prod_hi, prod_lo}, 16'h000E);
    check("t7_op", op_bad, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
